fpowi: RTL

Iterative integer-power unit: computes y = x^n for a 32-bit single-precision operand x and an unsigned integer exponent n, using right-to-left square-and-multiply. The unit owns no multiplier. It time-shares one instance of the team's combinational `fmul` block through a dedicated operand/result port pair, and is placed directly upstream of that multiplier. A valid/ready request and response handshake connects it to the FPU issue logic.

---
 rtl/fpowi.sv | 96 +++++++++
 1 files changed

// File: rtl/fpowi.sv
// fpowi: iterative y = x^n by right-to-left square-and-multiply, time-sharing
// one external combinational fmul through the mul_a/mul_b/mul_y port pair.
module fpowi #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      x,
  input  logic [NBITS-1:0] n,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      y,
  output logic             ovf,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  input  logic [31:0]      mul_y,
  input  logic             mul_ovf
);

  typedef enum logic [1:0] {IDLE, STEP, DONE} state_t;

  localparam logic [31:0] ONE_F = 32'h3F800000;

  state_t           r_state, w_state_next;
  logic [31:0]      r_acc, w_acc_next;
  logic [31:0]      r_base, w_base_next;
  logic [NBITS-1:0] r_e, w_e_next;
  logic             r_ovf, w_ovf_next;
  logic             w_sel_acc;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_base  <= '0;
      r_e     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_acc   <= w_acc_next;
      r_base  <= w_base_next;
      r_e     <= w_e_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Kept separate from the FSM block so mul_a depends only on registers.
  assign w_sel_acc = (r_state == STEP) && r_e[0];

  always_comb begin
    w_state_next = r_state;
    w_acc_next   = r_acc;
    w_base_next  = r_base;
    w_e_next     = r_e;
    w_ovf_next   = r_ovf;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_acc_next   = ONE_F;
          w_base_next  = x;
          w_e_next     = n;
          w_ovf_next   = 1'b0;
          w_state_next = STEP;
        end
      end
      STEP: begin
        if (r_e == '0) begin
          w_state_next = DONE;
        end else if (r_e[0]) begin
          w_acc_next = mul_y;
          w_e_next   = {r_e[NBITS-1:1], 1'b0};
          w_ovf_next = r_ovf | mul_ovf;
        end else begin
          // Square only while bits remain, so no wasted final square.
          w_base_next = mul_y;
          w_e_next    = r_e >> 1;
          w_ovf_next  = r_ovf | mul_ovf;
        end
      end
      DONE: begin
        if (resp_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign mul_a      = w_sel_acc ? r_acc : r_base;
  assign mul_b      = r_base;
  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == DONE);
  assign y          = r_acc;
  assign ovf        = r_ovf;

endmodule
